// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcodes, UART register offsets and TX FSM states.
package tl_pkg;

  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;

  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_BAUDDIV = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding the UART transmitter; show-ahead read port.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot for a push into a full queue.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tl_uart_tx_adapter.sv
// TileLink-UL slave exposing an 8N1 UART transmitter with a byte FIFO.
module tl_uart_tx_adapter
  import tl_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid_i,
  input  logic [2:0]  a_opcode_i,
  input  logic [11:0] a_address_i,
  input  logic [31:0] a_data_i,
  input  logic [1:0]  a_size_i,
  input  logic [1:0]  a_mask_i,
  output logic        d_valid_o,
  output logic [2:0]  d_opcode_o,
  output logic [1:0]  d_size_o,
  output logic [31:0] d_data_o,
  output logic        tx_o,
  output logic        busy_o
);

  uart_tx_state_t state;
  logic [15:0] baud_div;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        tx_q;
  logic        overflow;

  logic [1:0]  reg_sel;
  logic        is_put;
  logic        is_get;
  logic        wr_txdata;
  logic        wr_status;
  logic        wr_baud;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        frame_active;
  logic        overflow_set;
  logic [31:0] rdata;
  logic [15:0] baud_wr;

  logic unused_ok;
  assign unused_ok = ^{a_mask_i, a_address_i[11:4],
                       a_address_i[1:0], a_data_i[31:16]};

  assign reg_sel = a_address_i[3:2];

  always_comb begin
    is_put = 1'b0;
    is_get = 1'b0;
    unique case (1'b1)
      (a_opcode_i == TL_PUT_FULL),
      (a_opcode_i == TL_PUT_PARTIAL): is_put = 1'b1;
      (a_opcode_i == TL_GET):         is_get = 1'b1;
      default: ;
    endcase
  end

  assign wr_txdata = a_valid_i & is_put & (reg_sel == UART_TXDATA);
  assign wr_status = a_valid_i & is_put & (reg_sel == UART_STATUS);
  assign wr_baud   = a_valid_i & is_put & (reg_sel == UART_BAUDDIV);
  assign baud_wr   = (a_data_i[15:0] == 16'd0) ? 16'd1 : a_data_i[15:0];

  assign frame_active = (state != IDLE);
  assign fifo_pop     = (state == IDLE) & ~fifo_empty;
  assign overflow_set = wr_txdata & fifo_full & ~fifo_pop;

  assign tx_o   = tx_q;
  assign busy_o = frame_active | ~fifo_empty;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .din   (a_data_i[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rdata = 32'd0;
    unique case (reg_sel)
      UART_STATUS:  rdata = {28'd0, overflow, fifo_empty,
                             fifo_full, frame_active};
      UART_BAUDDIV: rdata = {16'd0, baud_div};
      default:      rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid_o  <= 1'b0;
      d_opcode_o <= TL_ACCESS_ACK;
      d_size_o   <= 2'd0;
      d_data_o   <= 32'd0;
    end else begin
      d_valid_o  <= a_valid_i;
      d_opcode_o <= is_get ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      d_size_o   <= a_size_i;
      d_data_o   <= (a_valid_i & is_get) ? rdata : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_div <= 16'(CLKS_PER_BIT);
      overflow <= 1'b0;
    end else begin
      if (wr_baud) baud_div <= baud_wr;
      // A fresh overflow outranks a clear in the same cycle.
      if (overflow_set)
        overflow <= 1'b1;
      else if (wr_status && a_data_i[3])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      shift   <= 8'd0;
      bit_idx <= 3'd0;
      bit_cnt <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (fifo_pop) begin
            shift   <= fifo_dout;
            bit_cnt <= baud_div - 16'd1;
            tx_q    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_cnt == 16'd0) begin
            bit_idx <= 3'd0;
            bit_cnt <= baud_div - 16'd1;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_cnt == 16'd0) begin
            bit_cnt <= baud_div - 16'd1;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_cnt == 16'd0)
            state <= IDLE;
          else
            bit_cnt <= bit_cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tl_uart_tx_adapter.md
Name: tl_uart_tx_adapter

Overview:
- Memory-mapped UART transmitter on the TileLink-UL style A/D bus.
- Sits directly downstream of a channel_a instance, in the same slot as data_mem_adapter. It consumes the A-channel request and returns a D-channel response that feeds a channel_d instance.
- Bytes written by the core are queued in a small FIFO and serialised 8N1 on tx_o. This gives the core a debug/console output path besides the LEDs.

Parameters:
- FIFO_DEPTH, 4, TX byte queue depth; must be a power of 2 and at least 2.
- CLKS_PER_BIT, 16, reset value of BAUDDIV (clock cycles per UART bit); range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- a_valid_i  input  1  A-channel request valid.
- a_opcode_i  input  3  A opcode: 0 PutFullData, 1 PutPartialData, 4 Get.
- a_address_i  input  12  byte address; only [3:2] is decoded.
- a_data_i  input  32  write data.
- a_size_i  input  2  transfer size; echoed back on D.
- a_mask_i  input  2  byte mask; ignored, all registers take full writes.
- d_valid_o  output  1  D-channel response valid.
- d_opcode_o  output  3  0 AccessAck, 1 AccessAckData.
- d_size_o  output  2  echo of a_size_i.
- d_data_o  output  32  read data; 0 for writes.
- tx_o  output  1  UART serial line; idles high.
- busy_o  output  1  high while a frame is shifting or the FIFO is non-empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - d_valid_o=0, d_opcode_o=0, d_size_o=0, d_data_o=0.
  - tx_o=1, busy_o=0.
  - FIFO empty, overflow flag=0, BAUDDIV=CLKS_PER_BIT, FSM=IDLE.
  - Reset mid-frame aborts the frame at once; tx_o returns high and the queued bytes are lost.
- Request acceptance:
  - No A-ready handshake. Every cycle with a_valid_i=1 is one accepted request.
  - Exactly one response follows: d_valid_o=1 for one cycle, one cycle after the request (latency 1, fully registered).
  - Back-to-back requests give back-to-back responses.
- Register map (offset = a_address_i[3:2]):
  - 0 TXDATA: write pushes a_data_i[7:0]; reads return 0.
  - 1 STATUS: reads return {28'b0, overflow, fifo_empty, fifo_full, frame_active}. Writing 1 to bit3 clears overflow; other bits are read-only.
  - 2 BAUDDIV: R/W, bits[15:0]; a write of 0 stores 1; upper read bits are 0.
  - 3: reserved; reads return 0, writes are ignored.
- Response encoding:
  - Get: d_opcode_o=1, d_data_o=register value sampled in the request cycle.
  - Put (opcode 0 or 1): d_opcode_o=0, d_data_o=0.
  - Any other opcode: AccessAck with no side effect.
  - In all cases d_size_o=a_size_i.
- FIFO:
  - Push on a TXDATA write.
  - A push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped, overflow is set sticky, and the response is still AccessAck.
  - Pointers wrap modulo FIFO_DEPTH.
  - The count has log2(FIFO_DEPTH)+1 bits.
- TX FSM (states IDLE, START, DATA, STOP):
  - IDLE: tx_o=1. If the FIFO is non-empty, pop into the shift register, load the bit counter with BAUDDIV-1, and go to START.
  - START: tx_o=0 for BAUDDIV cycles, then DATA with bit_idx=0.
  - DATA: tx_o=shift[bit_idx], LSB first, each bit held BAUDDIV cycles. After bit 7, go to STOP.
  - STOP: tx_o=1 for BAUDDIV cycles, then IDLE.
  - Back-to-back frames: from IDLE, a pending byte starts one cycle after STOP ends, giving a 1-cycle extra idle.
- Baud timing:
  - The bit-time counter reloads from the current BAUDDIV at each bit start.
  - A BAUDDIV write mid-frame therefore takes effect at the next bit boundary.
- Status bits:
  - frame_active=1 in START/DATA/STOP.
  - busy_o = frame_active | ~fifo_empty.
- Simultaneous events:
  - A STATUS read in the same cycle as a pop returns the pre-pop values.
  - An overflow-clear write in the same cycle as a new overflow leaves overflow=1 (set wins).

Decomposition:
- Shared package tl_pkg:
  - A opcodes: TL_PUT_FULL=3'd0, TL_PUT_PARTIAL=3'd1, TL_GET=3'd4.
  - D opcodes: TL_ACCESS_ACK=3'd0, TL_ACCESS_ACK_DATA=3'd1.
  - Register offsets: UART_TXDATA, UART_STATUS, UART_BAUDDIV.
  - uart_tx_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module: uart_tx_fifo, a synchronous FIFO with parameter DEPTH.
  - Ports: clk, reset, push, din[7:0], pop, dout[7:0], full, empty.
- The FSM and register decode stay in the top of the block.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> tx_o=1, busy_o=0, d_valid_o=0. A Get at 0x004 returns d_opcode_o=1, d_data_o=0x00000004 (empty only).
- Single byte: BAUDDIV=4, Put 0x55 to 0x000 -> AccessAck next cycle.
  - tx_o then shows start 0, bits 1,0,1,0,1,0,1,0 and stop 1, each held exactly 4 cycles (40 cycles total).
  - busy_o falls after the stop bit.
- Overflow: BAUDDIV=100, write 6 bytes 0x41..0x46 on consecutive cycles.
  - First byte pops immediately, so 0x41..0x45 are queued or transmitting and 0x46 is dropped.
  - STATUS reads 0x8 | fifo_full | frame_active = 0xB.
  - Write 0x8 to STATUS -> a later read shows bit3=0.
- BAUDDIV boundary: write 0 to 0x008, then read -> d_data_o=0x00000001. Send 0xFF -> 10 bit-times of 1 cycle each.
- Response latency/echo: Get at 0x00C with a_size_i=2 -> next cycle d_valid_o=1, d_opcode_o=1, d_size_o=2, d_data_o=0. Opcode 3'd2 -> AccessAck with no state change.
- Reset mid-frame: during DATA bit 3, assert reset=0 asynchronously -> tx_o=1 in the same cycle, FIFO empty, BAUDDIV=CLKS_PER_BIT after release.
